// File: rtl/mips_pkg.sv
// Shared constants and types for the stream demultiplexer datapath.
package mips_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;
  localparam logic DEST_0   = 1'b0;
  localparam logic DEST_1   = 1'b1;

  typedef enum logic {
    STATE_EMPTY = ST_EMPTY,
    STATE_FULL  = ST_FULL
  } state_t;
endpackage

// File: rtl/xfer_counter.sv
// Free-running transfer counter; wraps silently modulo 2^CNT_WIDTH.
module xfer_counter
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 valid/ready demultiplexer with one holding register and
// per-destination transfer counters.
module stream_demux
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_0_data,
  output logic                  out_0_valid,
  input  logic                  out_0_ready,
  output logic [DATA_WIDTH-1:0] out_1_data,
  output logic                  out_1_valid,
  input  logic                  out_1_ready,
  output logic [CNT_WIDTH-1:0]  cnt_0,
  output logic [CNT_WIDTH-1:0]  cnt_1
);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  sel_reg;

  logic full;
  logic drain;
  logic accept;

  assign full = (state_reg == STATE_FULL);

  // Only the addressed destination's ready can drain the held beat.
  assign drain    = full && ((sel_reg == DEST_1) ? out_1_ready : out_0_ready);
  assign in_ready = !full || drain;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= STATE_EMPTY;
      data_reg  <= '0;
      sel_reg   <= DEST_0;
    end else if (accept) begin
      state_reg <= STATE_FULL;
      data_reg  <= in_data;
      sel_reg   <= in_sel;
    end else if (drain) begin
      state_reg <= STATE_EMPTY;
    end
  end

  assign out_0_data  = data_reg;
  assign out_1_data  = data_reg;
  assign out_0_valid = full && (sel_reg == DEST_0);
  assign out_1_valid = full && (sel_reg == DEST_1);

  xfer_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_0 (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_0_valid && out_0_ready),
    .count(cnt_0)
  );

  xfer_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_1 (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_1_valid && out_1_ready),
    .count(cnt_1)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus random traffic
// against a queue-based model of a one-beat buffer.
module tb_stream_demux;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        out_0_ready;
  logic        out_1_ready;

  logic        in_ready;
  logic [31:0] out_0_data, out_1_data;
  logic        out_0_valid, out_1_valid;
  logic [15:0] cnt_0, cnt_1;

  logic        in_ready_w;
  logic [31:0] out_0_data_w, out_1_data_w;
  logic        out_0_valid_w, out_1_valid_w;
  logic [3:0]  cnt_0_w, cnt_1_w;

  stream_demux #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_0_data(out_0_data), .out_0_valid(out_0_valid), .out_0_ready(out_0_ready),
    .out_1_data(out_1_data), .out_1_valid(out_1_valid), .out_1_ready(out_1_ready),
    .cnt_0(cnt_0), .cnt_1(cnt_1)
  );

  // Narrow-counter instance shares all inputs, used for wrap-around checks.
  stream_demux #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready_w),
    .out_0_data(out_0_data_w), .out_0_valid(out_0_valid_w), .out_0_ready(out_0_ready),
    .out_1_data(out_1_data_w), .out_1_valid(out_1_valid_w), .out_1_ready(out_1_ready),
    .cnt_0(cnt_0_w), .cnt_1(cnt_1_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sel;
  } beat_t;

  beat_t       pend[$];
  logic [31:0] last_data;
  int          exp_cnt0, exp_cnt1;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_counts();
    chk("cnt_0", 32'(cnt_0), 32'(exp_cnt0 % 65536));
    chk("cnt_1", 32'(cnt_1), 32'(exp_cnt1 % 65536));
    chk("cnt_0_w", 32'(cnt_0_w), 32'(exp_cnt0 % 16));
    chk("cnt_1_w", 32'(cnt_1_w), 32'(exp_cnt1 % 16));
  endtask

  // One clock cycle: drive, check outputs at negedge, advance the model.
  task automatic step(input logic [31:0] d, input logic s, input logic v,
                      input logic r0, input logic r1);
    logic        ev0, ev1, er, done0, done1;
    logic [31:0] ed;
    in_data = d; in_sel = s; in_valid = v; out_0_ready = r0; out_1_ready = r1;
    @(negedge clk);
    ev0   = (pend.size() != 0) && (pend[0].sel == 1'b0);
    ev1   = (pend.size() != 0) && (pend[0].sel == 1'b1);
    done0 = ev0 && r0;
    done1 = ev1 && r1;
    er    = (pend.size() == 0) || done0 || done1;
    ed    = (pend.size() != 0) ? pend[0].data : last_data;
    $display("cycle t=%0t in v=%0b s=%0b d=%h | out0 v=%0b out1 v=%0b d=%h rdy=%0b",
             $time, v, s, d, out_0_valid, out_1_valid, out_0_data, in_ready);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_0_valid", 32'(out_0_valid), 32'(ev0));
    chk("out_1_valid", 32'(out_1_valid), 32'(ev1));
    chk("out_0_data", out_0_data, ed);
    chk("out_1_data", out_1_data, ed);
    chk("in_ready_w", 32'(in_ready_w), 32'(er));
    @(posedge clk);
    if (done0) exp_cnt0++;
    if (done1) exp_cnt1++;
    if (done0 || done1) void'(pend.pop_front());
    if (v && er) begin
      pend.push_back('{data: d, sel: s});
      last_data = d;
    end
    #1;
    check_counts();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    pend.delete();
    last_data = '0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_0_valid", 32'(out_0_valid), 32'd0);
    chk("rst_out_1_valid", 32'(out_1_valid), 32'd0);
    chk("rst_data", out_0_data, 32'd0);
    check_counts();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    exp_cnt0 = 0; exp_cnt1 = 0; last_data = '0;
    rst_n = 1'b0;
    in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out_0_ready = 1'b0; out_1_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset while a beat is held: it must be dropped.
    step(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Single beat to destination 1.
    do_reset();
    step(32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("single_cnt_1", 32'(cnt_1), 32'd1);
    chk("single_cnt_0", 32'(cnt_0), 32'd0);

    // Streaming, alternating destinations at one beat per cycle.
    do_reset();
    for (int i = 1; i <= 8; i++) step(32'(i), ((i % 2) == 0), 1'b1, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("stream_cnt_0", 32'(cnt_0), 32'd4);
    chk("stream_cnt_1", 32'(cnt_1), 32'd4);

    // Backpressure on destination 0 while a producer keeps offering.
    do_reset();
    step(32'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(32'hBB, 1'b1, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_cnt_0", 32'(cnt_0), 32'd1);
    chk("bp_cnt_1", 32'(cnt_1), 32'd0);

    // Drain and accept in the same cycle.
    do_reset();
    step(32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    step(32'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sim_cnt_0", 32'(cnt_0), 32'd1);
    chk("sim_cnt_1", 32'(cnt_1), 32'd1);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      step(32'(i), 1'b0, (i <= 17), 1'b1, 1'b1);
      if (exp_cnt0 == 15 && i == 16) chk("wrap_15", 32'(cnt_0_w), 32'd15);
      if (exp_cnt0 == 16 && i == 17) chk("wrap_16", 32'(cnt_0_w), 32'd0);
      if (exp_cnt0 == 17 && i == 18) chk("wrap_17", 32'(cnt_0_w), 32'd1);
    end

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
